time_set_ctrl: RTL and testbench

- Button-input front end for the MM:SS digital clock; it is the input-side counterpart to the display output path.
- Synchronises and debounces two push-buttons (mode, increment) and runs a set-time state machine.
- Edits a shadow copy of the BCD minutes/seconds and issues a one-cycle load pulse with the new time to the seconds/minutes counter.
- Provides a digit-blank mask so the display path can blink the field being edited.

---
 rtl/time_set_ctrl_if.sv | 28 ++
 rtl/time_set_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_time_set_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/time_set_ctrl_if.sv
// Button / time bus between the set-time controller and its surroundings.
// The master side owns the raw buttons and the live time; the slave side
// (the controller) returns the edited time, the load strobe and blink mask.
interface time_set_ctrl_if;
    logic       btn_mode;
    logic       btn_inc;
    logic [3:0] cur_sec1;
    logic [2:0] cur_sec2;
    logic [3:0] cur_min1;
    logic [2:0] cur_min2;
    logic       load;
    logic [3:0] set_sec1;
    logic [2:0] set_sec2;
    logic [3:0] set_min1;
    logic [2:0] set_min2;
    logic       setting;
    logic [3:0] blank;

    modport master (
        output btn_mode, btn_inc, cur_sec1, cur_sec2, cur_min1, cur_min2,
        input  load, set_sec1, set_sec2, set_min1, set_min2, setting, blank
    );

    modport slave (
        input  btn_mode, btn_inc, cur_sec1, cur_sec2, cur_min1, cur_min2,
        output load, set_sec1, set_sec2, set_min1, set_min2, setting, blank
    );
endinterface

// File: rtl/time_set_ctrl.sv
// Set-time front end for the MM:SS clock: synchronises and debounces the
// mode/increment buttons, edits a shadow copy of the time (minutes first,
// then seconds), pulses load when the edit is committed and produces a
// blink mask for the field under edit. All outputs come straight from flops.
module time_set_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int BLINK_CYCLES    = 25_000_000
) (
    input  logic           clk_100MHZ,
    input  logic           reset,
    time_set_ctrl_if.slave bus
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [DW-1:0] DB_MAX    = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_MIN = 2'd1,
        ST_SET_SEC = 2'd2
    } state_t;

    // Advance a tens/units BCD pair by one modulo 60. Out-of-range inputs are
    // pulled back into range: tens above 5 restart at 0, units of 9 or more
    // roll to 0 and carry.
    function automatic logic [6:0] bcd_inc60(input logic [2:0] tens,
                                             input logic [3:0] units);
        logic [2:0] t_norm;
        logic [2:0] t_out;
        logic [3:0] u_out;
        t_norm = (tens > 3'd5) ? 3'd0 : tens;
        if (units >= 4'd9) begin
            u_out = 4'd0;
            t_out = (t_norm == 3'd5) ? 3'd0 : t_norm + 3'd1;
        end else begin
            u_out = units + 4'd1;
            t_out = t_norm;
        end
        return {t_out, u_out};
    endfunction

    // Button conditioning: index 0 = mode, index 1 = inc
    logic [1:0]    w_raw;
    logic [1:0]    r_sync1;
    logic [1:0]    r_sync2;
    logic [1:0]    r_db;
    logic [DW-1:0] r_db_cnt [2];
    logic [1:0]    w_rise;
    logic          w_mode_press;
    logic          w_inc_press;

    // Edit state
    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_sec1, w_sec1_nxt;
    logic [2:0]    r_sec2, w_sec2_nxt;
    logic [3:0]    r_min1, w_min1_nxt;
    logic [2:0]    r_min2, w_min2_nxt;
    logic          r_load, w_load_nxt;
    logic          r_setting, w_setting_nxt;
    logic [3:0]    r_blank, w_blank_nxt;
    logic [BW-1:0] r_blink_cnt, w_blink_cnt_nxt;
    logic          r_phase, w_phase_nxt;

    assign w_raw = {bus.btn_inc, bus.btn_mode};

    // Two-flop synchroniser followed by a stability counter per button; the
    // debounced level only follows after DEBOUNCE_CYCLES unchanged samples.
    always_ff @(posedge clk_100MHZ) begin
        if (!reset) begin
            r_sync1     <= 2'b00;
            r_sync2     <= 2'b00;
            r_db        <= 2'b00;
            r_db_cnt[0] <= '0;
            r_db_cnt[1] <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DB_MAX) begin
                    r_db[i]     <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Press event: the cycle in which the debounced level is about to go 0->1.
    always_comb begin
        w_rise = 2'b00;
        for (int i = 0; i < 2; i++) begin
            w_rise[i] = r_sync2[i] & ~r_db[i] & (r_db_cnt[i] == DB_MAX);
        end
        w_mode_press = w_rise[0];
        w_inc_press  = w_rise[1];
    end

    // Next state, shadow time, load strobe and blink mask; mode beats inc.
    always_comb begin
        w_state_nxt = r_state;
        w_sec1_nxt  = r_sec1;
        w_sec2_nxt  = r_sec2;
        w_min1_nxt  = r_min1;
        w_min2_nxt  = r_min2;
        w_load_nxt  = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_mode_press) begin
                    w_sec1_nxt  = bus.cur_sec1;
                    w_sec2_nxt  = bus.cur_sec2;
                    w_min1_nxt  = bus.cur_min1;
                    w_min2_nxt  = bus.cur_min2;
                    w_state_nxt = ST_SET_MIN;
                end
            end
            ST_SET_MIN: begin
                if (w_mode_press) begin
                    w_state_nxt = ST_SET_SEC;
                end else if (w_inc_press) begin
                    {w_min2_nxt, w_min1_nxt} = bcd_inc60(r_min2, r_min1);
                end
            end
            ST_SET_SEC: begin
                if (w_mode_press) begin
                    w_state_nxt = ST_RUN;
                    w_load_nxt  = 1'b1;
                end else if (w_inc_press) begin
                    {w_sec2_nxt, w_sec1_nxt} = bcd_inc60(r_sec2, r_sec1);
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase

        // Blink restarts visible on every state entry and only runs while editing
        w_blink_cnt_nxt = r_blink_cnt;
        w_phase_nxt     = r_phase;
        if ((w_state_nxt != r_state) || (w_state_nxt == ST_RUN)) begin
            w_blink_cnt_nxt = '0;
            w_phase_nxt     = 1'b0;
        end else if (r_blink_cnt == BLINK_MAX) begin
            w_blink_cnt_nxt = '0;
            w_phase_nxt     = ~r_phase;
        end else begin
            w_blink_cnt_nxt = r_blink_cnt + 1'b1;
        end

        w_setting_nxt = (w_state_nxt != ST_RUN);
        case (w_state_nxt)
            ST_SET_MIN: w_blank_nxt = {w_phase_nxt, w_phase_nxt, 2'b00};
            ST_SET_SEC: w_blank_nxt = {2'b00, w_phase_nxt, w_phase_nxt};
            default:    w_blank_nxt = 4'b0000;
        endcase
    end

    // State register
    always_ff @(posedge clk_100MHZ) begin
        if (!reset) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Blink timer and phase
    always_ff @(posedge clk_100MHZ) begin
        if (!reset) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else begin
            r_blink_cnt <= w_blink_cnt_nxt;
            r_phase     <= w_phase_nxt;
        end
    end

    // Registered outputs; reset discards any edit in progress without a load
    always_ff @(posedge clk_100MHZ) begin
        if (!reset) begin
            r_sec1    <= 4'd0;
            r_sec2    <= 3'd0;
            r_min1    <= 4'd0;
            r_min2    <= 3'd0;
            r_load    <= 1'b0;
            r_setting <= 1'b0;
            r_blank   <= 4'b0000;
        end else begin
            r_sec1    <= w_sec1_nxt;
            r_sec2    <= w_sec2_nxt;
            r_min1    <= w_min1_nxt;
            r_min2    <= w_min2_nxt;
            r_load    <= w_load_nxt;
            r_setting <= w_setting_nxt;
            r_blank   <= w_blank_nxt;
        end
    end

    assign bus.load     = r_load;
    assign bus.set_sec1 = r_sec1;
    assign bus.set_sec2 = r_sec2;
    assign bus.set_min1 = r_min1;
    assign bus.set_min2 = r_min2;
    assign bus.setting  = r_setting;
    assign bus.blank    = r_blank;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: directed scenarios with hand-computed expectations
// plus random button/time traffic, all checked every cycle against a
// window-based behavioural model of debounce, editing and blinking.
module tb_time_set_ctrl;

    localparam int D = 4;
    localparam int B = 8;
    localparam int S_RUN = 0;
    localparam int S_MIN = 1;
    localparam int S_SEC = 2;

    logic clk;
    logic reset;
    time_set_ctrl_if bus();

    time_set_ctrl #(.DEBOUNCE_CYCLES(D), .BLINK_CYCLES(B)) dut (
        .clk_100MHZ (clk),
        .reset      (reset),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int load_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit mq[$];
    bit iq[$];
    bit m_db, i_db;
    bit m_valid = 0;
    int m_state;
    int m_mt, m_mu, m_st, m_su;
    int m_load;
    int m_k;

    // Debounced level flips once the D raw samples that have fully crossed the
    // synchroniser all disagree with it.
    function automatic bit will_flip(input bit q[$], input bit db);
        for (int j = q.size() - 1 - D; j <= q.size() - 2; j++)
            if (q[j] == db) return 1'b0;
        return 1'b1;
    endfunction

    // Value-level mod-60 increment with out-of-range digits normalised first.
    function automatic int inc60(input int t, input int u);
        int v;
        v = ((t > 5) ? 0 : t) * 10 + ((u > 9) ? 9 : u) + 1;
        return v % 60;
    endfunction

    always @(posedge clk) begin
        bit mf, ifl, mp, ip;
        int nxt, v;
        if (reset === 1'b0) begin
            mq.delete(); iq.delete();
            for (int j = 0; j < D + 2; j++) begin mq.push_back(0); iq.push_back(0); end
            m_db = 0; i_db = 0;
            m_state = S_RUN; m_mt = 0; m_mu = 0; m_st = 0; m_su = 0;
            m_load = 0; m_k = 0; m_valid = 1;
        end else if (m_valid) begin
            mf = will_flip(mq, m_db);
            ifl = will_flip(iq, i_db);
            if (mf) m_db = ~m_db;
            if (ifl) i_db = ~i_db;
            mp = mf && m_db;
            ip = ifl && i_db;
            mq.push_back(bus.btn_mode); void'(mq.pop_front());
            iq.push_back(bus.btn_inc);  void'(iq.pop_front());
            m_load = 0;
            nxt = m_state;
            if (mp) begin
                if (m_state == S_RUN) begin
                    m_mt = bus.cur_min2; m_mu = bus.cur_min1;
                    m_st = bus.cur_sec2; m_su = bus.cur_sec1;
                    nxt = S_MIN;
                end else if (m_state == S_MIN) begin
                    nxt = S_SEC;
                end else begin
                    nxt = S_RUN; m_load = 1;
                end
            end else if (ip) begin
                if (m_state == S_MIN) begin
                    v = inc60(m_mt, m_mu); m_mt = v / 10; m_mu = v % 10;
                end else if (m_state == S_SEC) begin
                    v = inc60(m_st, m_su); m_st = v / 10; m_su = v % 10;
                end
            end
            if (nxt != m_state || nxt == S_RUN) m_k = 0;
            else m_k++;
            m_state = nxt;
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        int ph, eb;
        if (m_valid) begin
            ph = (m_k / B) % 2;
            eb = (m_state == S_MIN) ? ph * 12 : (m_state == S_SEC) ? ph * 3 : 0;
            chk("model_load", bus.load, m_load);
            chk("model_setting", bus.setting, (m_state != S_RUN) ? 1 : 0);
            chk("model_blank", bus.blank, eb);
            chk("model_min2", bus.set_min2, m_mt);
            chk("model_min1", bus.set_min1, m_mu);
            chk("model_sec2", bus.set_sec2, m_st);
            chk("model_sec1", bus.set_sec1, m_su);
            if (bus.load === 1'b1) load_cnt++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_cur(input int mm, input int ss);
        bus.cur_min2 = 3'(mm / 10); bus.cur_min1 = 4'(mm % 10);
        bus.cur_sec2 = 3'(ss / 10); bus.cur_sec1 = 4'(ss % 10);
    endtask

    task automatic press(input bit m, input bit i);
        if (m) bus.btn_mode = 1'b1;
        if (i) bus.btn_inc = 1'b1;
        repeat (8) @(negedge clk);
        bus.btn_mode = 1'b0;
        bus.btn_inc = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic chk_time(input string name, input int mm, input int ss);
        chk({name, "_min"}, bus.set_min2 * 10 + bus.set_min1, mm);
        chk({name, "_sec"}, bus.set_sec2 * 10 + bus.set_sec1, ss);
    endtask

    // Hold mode for the press, then watch the blink pattern from the entry cycle
    task automatic blink_entry(input string name, input int n, input logic [3:0] mask);
        bus.btn_mode = 1'b1;
        repeat (6) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            chk(name, bus.blank, ((i / 8) % 2) ? mask : 4'b0000);
            @(negedge clk);
        end
        bus.btn_mode = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        int lc, sel, hold, gap;
        reset = 1'b0;
        bus.btn_mode = 1'b0;
        bus.btn_inc = 1'b0;
        set_cur(0, 0);

        // Reset held with buttons chattering
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.btn_mode = 1'($urandom_range(0, 1));
            bus.btn_inc  = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        chk("rst_load", bus.load, 0);
        chk("rst_setting", bus.setting, 0);
        chk("rst_blank", bus.blank, 0);
        chk_time("rst_set", 0, 0);
        bus.btn_mode = 1'b0;
        bus.btn_inc = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        set_cur(12, 58);
        repeat (20) @(negedge clk);
        chk("idle_setting", bus.setting, 0);
        chk_time("idle_set", 0, 0);

        // Bounce rejection, then one clean press
        for (int i = 0; i < 10; i++) begin
            bus.btn_mode = ~bus.btn_mode;
            repeat (2) @(negedge clk);
        end
        chk("bounce_reject", bus.setting, 0);
        bus.btn_mode = 1'b1;
        repeat (5) @(negedge clk);
        chk("setting_lat5", bus.setting, 0);
        @(negedge clk);
        chk("setting_lat6", bus.setting, 1);
        chk_time("entry_copy", 12, 58);
        repeat (4) @(negedge clk);
        for (int i = 0; i < 11; i++) begin
            bus.btn_mode = ~bus.btn_mode;
            repeat (2) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        chk("release_no_event", bus.setting, 1);
        chk("release_min_blank", bus.blank[1:0], 0);

        // Full edit
        repeat (48) press(0, 1);
        chk_time("min_wrap", 0, 58);
        press(1, 0);
        repeat (3) press(0, 1);
        chk_time("sec_wrap", 0, 1);
        lc = load_cnt;
        press(1, 0);
        chk("load_once", load_cnt - lc, 1);
        chk("after_load_setting", bus.setting, 0);
        chk_time("after_load", 0, 1);

        // BCD carry
        set_cur(9, 30);
        press(1, 0);
        press(0, 1);
        chk_time("carry_09", 10, 30);
        press(1, 0);
        press(1, 0);
        set_cur(59, 17);
        press(1, 0);
        press(0, 1);
        chk_time("carry_59", 0, 17);
        press(1, 0);
        press(1, 0);

        // Blink in SET_SEC, then fresh phase on entering SET_MIN
        press(1, 0);
        blink_entry("blink_sec", 32, 4'b0011);
        press(1, 0);
        blink_entry("blink_min", 16, 4'b1100);
        chk_time("min_entry", 59, 17);

        // Simultaneous mode+inc, then reset mid-edit
        press(1, 1);
        chk("simul_setting", bus.setting, 1);
        chk_time("simul", 59, 17);
        lc = load_cnt;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_no_load", load_cnt - lc, 0);
        chk("abort_setting", bus.setting, 0);
        chk_time("abort_set", 0, 0);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // Random traffic, including out-of-range live digits and glitches
        for (int it = 0; it < 80; it++) begin
            bus.cur_min1 = 4'($urandom_range(0, 15));
            bus.cur_min2 = 3'($urandom_range(0, 7));
            bus.cur_sec1 = 4'($urandom_range(0, 15));
            bus.cur_sec2 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 24) == 0) begin
                reset = 1'b0;
                repeat (2) @(negedge clk);
                reset = 1'b1;
            end
            sel  = $urandom_range(0, 3);
            hold = $urandom_range(1, 10);
            gap  = $urandom_range(1, 10);
            bus.btn_mode = sel[0];
            bus.btn_inc  = sel[1];
            repeat (hold) @(negedge clk);
            bus.btn_mode = 1'b0;
            bus.btn_inc  = 1'b0;
            repeat (gap) @(negedge clk);
        end
        repeat (10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
